// File: rtl/freq_meter.sv
// freq_meter
// Measures the period and high time of a slow square wave in clk cycles.
// sig_in is synchronised (two flops) and delayed once more to form rise/fall
// strobes. After arming, the first rise starts a measurement; every further
// rise closes one period and emits a one-cycle period_valid pulse.
// A stall of TIMEOUT cycles without a rise raises the sticky timeout flag.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   en           measurement enable (level)
//   sig_in       asynchronous square wave under measurement
//   period       cycles between the last two rising edges
//   high_time    cycles sig_in was high in the last completed period
//   period_valid one-cycle pulse when period/high_time update
//   timeout      sticky stall flag
//   rise_pulse   one-cycle pulse per detected rising edge
module freq_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             timeout,
  output logic             rise_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  // Stall counter terminal value: reaching it without a rise ends the wait.
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sync_s1_reg, sync_s2_reg, edge_s3_reg;
  logic rise, fall;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hi_cnt_reg, hi_cnt_next;
  logic             high_seen_reg, high_seen_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_time_reg, high_time_next;
  logic             period_valid_reg, period_valid_next;
  logic             timeout_reg, timeout_next;
  logic             rise_pulse_reg;

  assign rise = sync_s2_reg & ~edge_s3_reg;
  assign fall = ~sync_s2_reg & edge_s3_reg;

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    hi_cnt_next       = hi_cnt_reg;
    high_seen_next    = high_seen_reg;
    period_next       = period_reg;
    high_time_next    = high_time_reg;
    period_valid_next = 1'b0;
    timeout_next      = timeout_reg;

    case (state_reg)
      IDLE: begin
        cnt_next       = '0;
        high_seen_next = 1'b0;
        if (en) state_next = ARM;
      end
      ARM: begin
        // Waiting for the reference rise; the counter doubles as stall timer.
        if (rise) begin
          cnt_next       = '0;
          high_seen_next = 1'b0;
          state_next     = MEAS;
        end else if (cnt_reg == TERM_CNT) begin
          timeout_next = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      MEAS: begin
        // A rise on the terminal-count cycle still completes the period.
        if (rise) begin
          period_next       = cnt_reg + CNT_ONE;
          high_time_next    = high_seen_reg ? hi_cnt_reg : '0;
          period_valid_next = 1'b1;
          timeout_next      = 1'b0;
          cnt_next          = '0;
          high_seen_next    = 1'b0;
        end else if (cnt_reg == TERM_CNT) begin
          timeout_next   = 1'b1;
          cnt_next       = '0;
          high_seen_next = 1'b0;
          state_next     = ARM;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
          // Only the first fall of a period defines the high time.
          if (fall && !high_seen_reg) begin
            hi_cnt_next    = cnt_reg + CNT_ONE;
            high_seen_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Disable overrides everything: discard the period, keep the results.
    if (!en) begin
      state_next        = IDLE;
      cnt_next          = '0;
      high_seen_next    = 1'b0;
      period_next       = period_reg;
      high_time_next    = high_time_reg;
      period_valid_next = 1'b0;
      timeout_next      = timeout_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_s1_reg      <= 1'b0;
      sync_s2_reg      <= 1'b0;
      edge_s3_reg      <= 1'b0;
      rise_pulse_reg   <= 1'b0;
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      hi_cnt_reg       <= '0;
      high_seen_reg    <= 1'b0;
      period_reg       <= '0;
      high_time_reg    <= '0;
      period_valid_reg <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      sync_s1_reg      <= sig_in;
      sync_s2_reg      <= sync_s1_reg;
      edge_s3_reg      <= sync_s2_reg;
      rise_pulse_reg   <= rise;
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      hi_cnt_reg       <= hi_cnt_next;
      high_seen_reg    <= high_seen_next;
      period_reg       <= period_next;
      high_time_reg    <= high_time_next;
      period_valid_reg <= period_valid_next;
      timeout_reg      <= timeout_next;
    end
  end

  assign period       = period_reg;
  assign high_time    = high_time_reg;
  assign period_valid = period_valid_reg;
  assign timeout      = timeout_reg;
  assign rise_pulse   = rise_pulse_reg;

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: directed scenarios followed by random waveforms,
// every cycle compared against a timestamp-based reference model.
module tb_freq_meter;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             timeout;
  logic             rise_pulse;

  freq_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .period(period), .high_time(high_time), .period_valid(period_valid),
    .timeout(timeout), .rise_pulse(rise_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: the meter sees sig_in two samples late; measurements
  // are differences between the timestamps of those seen edges.
  bit q0, q1, q2;           // samples of sig_in at the last three edges
  int mode = 0;             // 0 disabled, 1 waiting for start rise, 2 measuring
  int t_ref, t_start, t_fall;
  int m_period = 0, m_high = 0;
  bit m_pv = 0, m_to = 0, m_rp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_step();
    bit r, f;
    r = q1 & ~q2;
    f = ~q1 & q2;
    if (rst) begin
      q0 = 0; q1 = 0; q2 = 0;
      mode = 0; m_period = 0; m_high = 0; m_pv = 0; m_to = 0; m_rp = 0;
      return;
    end
    q2 = q1; q1 = q0; q0 = sig_in;
    m_rp = r;
    m_pv = 0;
    if (!en) begin
      mode = 0;
    end else if (mode == 0) begin
      mode = 1;
      t_ref = cyc;
    end else if (mode == 1) begin
      if (r) begin
        mode = 2; t_start = cyc; t_fall = -1;
      end else if (cyc - t_ref == TIMEOUT) begin
        m_to = 1; t_ref = cyc;
      end
    end else begin
      if (r) begin
        m_period = cyc - t_start;
        m_high   = (t_fall >= 0) ? t_fall - t_start : 0;
        m_pv = 1; m_to = 0;
        t_start = cyc; t_fall = -1;
      end else if (cyc - t_start == TIMEOUT) begin
        m_to = 1; mode = 1; t_ref = cyc;
      end else if (f && t_fall < 0) begin
        t_fall = cyc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("period", period, m_period);
    chk("high_time", high_time, m_high);
    chk("period_valid", {31'd0, period_valid}, {31'd0, m_pv});
    chk("timeout", {31'd0, timeout}, {31'd0, m_to});
    chk("rise_pulse", {31'd0, rise_pulse}, {31'd0, m_rp});
  endtask

  // Drive n periods of hi/lo, counting valid and rise pulses seen.
  int pv_seen, rp_seen;
  task automatic wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      sig_in = 1'b1;
      for (int i = 0; i < hi; i++) begin
        tick(); pv_seen += period_valid; rp_seen += rise_pulse;
      end
      sig_in = 1'b0;
      for (int i = 0; i < lo; i++) begin
        tick(); pv_seen += period_valid; rp_seen += rise_pulse;
      end
    end
  endtask

  int n;
  int hi, lo, r;

  initial begin
    // 1: reset with sig_in toggling, then latency of rise_pulse with en=0
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sig_in = ~sig_in;
      tick();
      chk("rst_outputs", {period[7:0], high_time[7:0], period_valid, timeout, rise_pulse}, '0);
    end
    rst = 1'b0; sig_in = 1'b0;
    repeat (4) tick();
    sig_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rise_pulse) begin n = i; break; end
    end
    chk("rise_latency", n, 3);

    // 2: steady 25/25 wave, four periods from arming
    sig_in = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    repeat (2) tick();
    pv_seen = 0;
    wave(25, 25, 4);
    chk("valid_count_25_25", pv_seen, 3);
    chk("period_25_25", period, 50);
    chk("high_25_25", high_time, 25);

    // 3: stall after a rise, timeout exactly TIMEOUT cycles later
    sig_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rise_pulse) break;
    end
    for (int i = 1; i <= 150; i++) begin
      if (i == 5) sig_in = 1'b0;
      tick();
      if (timeout) begin n = i; break; end
    end
    chk("timeout_delay", n, TIMEOUT);
    chk("period_held_timeout", period, 50);
    repeat (20) tick();
    wave(40, 60, 3);
    chk("timeout_cleared", {31'd0, timeout}, 0);
    chk("period_40_60", period, 100);
    chk("high_40_60", high_time, 40);

    // 4: duty-cycle extremes
    rp_seen = 0;
    wave(1, 9, 5);
    chk("rises_1_9", rp_seen, 5);
    chk("high_1_9", high_time, 1);
    rp_seen = 0;
    wave(9, 1, 5);
    chk("rises_9_1", rp_seen, 5);
    chk("period_9_1", period, 10);
    chk("high_9_1", high_time, 9);

    // 5: enable dropped mid-period
    wave(30, 30, 3);
    chk("period_before_drop", period, 60);
    sig_in = 1'b1;
    repeat (10) tick();
    en = 1'b0;
    pv_seen = 0;
    wave(10, 30, 2);
    chk("period_held_en0", period, 60);
    chk("no_valid_en0", pv_seen, 0);
    en = 1'b1;
    pv_seen = 0;
    wave(20, 15, 3);
    chk("valid_after_reenable", pv_seen, 2);
    chk("period_after_reenable", period, 35);

    // 6: reset in the middle of a measurement
    sig_in = 1'b1;
    repeat (8) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_mid_period", period, 0);
    pv_seen = 0;
    wave(12, 13, 3);
    chk("valid_after_rst", pv_seen, 2);

    // 7: random waveforms with occasional disable and reset
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        rst = 1'b1; tick(); tick(); rst = 1'b0;
      end else if (r == 1) begin
        en = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        en = 1'b1;
      end
      hi = $urandom_range(1, 70);
      lo = $urandom_range(1, 70);
      wave(hi, lo, 1);
    end
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
